// File: rtl/sample_reader_pkg.sv
// Shared definitions for the sample readout controller: state encoding,
// counter widths and parameter defaults.
package sample_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_VALID = 3'd1,
    ST_SEND       = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_NEXT       = 3'd4,
    ST_DONE       = 3'd5,
    ST_ERROR      = 3'd6
  } state_e;

  localparam int NEXT_LEN_DEF = 2;
  localparam int TIMEOUT_DEF  = 255;
  localparam int COUNT_W      = 11;
  localparam int TIMER_W      = 8;
  // Cycles after an accepted start during which i_idle is still expected high.
  localparam logic [1:0] START_GUARD = 2'd2;

endpackage

// File: rtl/sample_reader_pulse_stretcher.sv
// Turns a one-cycle trigger into a registered pulse LEN cycles long;
// o_last flags the final high cycle so the caller can move on.
module pulse_stretcher #(
  parameter int LEN = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_trig,
  input  logic i_clear,
  output logic o_pulse,
  output logic o_last
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_trig) begin
      cnt_d = CW'(LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
    pulse_d = (cnt_d != '0);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;
  assign o_last  = pulse_q && (cnt_q == ONE);

endmodule

// File: rtl/sample_reader.sv
// Reads NUM_SAMPLES samples out of a handshaking sampler and forwards each
// one to a serial transmitter, with timeout and sampler-abort detection.
module sample_reader
  import sample_reader_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int NUM_SAMPLES = 1024,
  parameter int NEXT_LEN    = NEXT_LEN_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_valid,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic                 i_idle,
  output logic                 o_next,
  output logic [DATA_SIZE-1:0] o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [COUNT_W-1:0]   o_count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX   = COUNT_W'(NUM_SAMPLES);
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT);

  state_e               state_q, state_d;
  logic                 last_valid_q;
  logic [DATA_SIZE-1:0] buf_q, buf_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [TIMER_W-1:0]   timer_q, timer_d, timer_next;
  logic [1:0]           guard_q, guard_d;
  logic                 tx_start_q, done_q, error_q, busy_q;
  logic                 valid_rise, next_trig, next_clear, next_last;

  assign valid_rise = i_valid && !last_valid_q;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    timer_d    = timer_q;
    guard_d    = (guard_q != '0) ? guard_q - 2'd1 : '0;
    timer_next = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (i_start) begin
          state_d = ST_WAIT_VALID;
          count_d = '0;
          guard_d = START_GUARD;
        end
      end
      ST_WAIT_VALID: begin
        if (i_idle && guard_q == '0) begin
          state_d = ST_ERROR;
        end else if (valid_rise) begin
          buf_d   = i_data;
          state_d = ST_SEND;
        end else if (timer_next == TIMER_LIMIT) begin
          state_d = ST_ERROR;
        end else begin
          timer_d = timer_next;
        end
      end
      ST_SEND: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          count_d = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
          state_d = (count_d == COUNT_MAX) ? ST_DONE : ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (i_idle) begin
          state_d = ST_ERROR;
        end else if (next_last) begin
          state_d = ST_WAIT_VALID;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Every entry into WAIT_VALID starts a fresh timeout window.
    if (state_d == ST_WAIT_VALID && state_q != ST_WAIT_VALID) begin
      timer_d = '0;
    end
  end

  // The stretcher fires on entry to NEXT and is cut short on any other exit.
  assign next_trig  = (state_d == ST_NEXT) && (state_q != ST_NEXT);
  assign next_clear = (state_d != ST_NEXT);

  pulse_stretcher #(
    .LEN (NEXT_LEN)
  ) u_next (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_trig  (next_trig),
    .i_clear (next_clear),
    .o_pulse (o_next),
    .o_last  (next_last)
  );

  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      state_q      <= ST_IDLE;
      last_valid_q <= 1'b0;
      buf_q        <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      guard_q      <= '0;
      tx_start_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_valid_q <= i_valid;
      buf_q        <= buf_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      guard_q      <= guard_d;
      tx_start_q   <= (state_d == ST_SEND);
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERROR);
      busy_q       <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
    end
  end

  assign o_tx_data  = buf_q;
  assign o_tx_start = tx_start_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_busy     = busy_q;
  assign o_count    = count_q;

endmodule
